// File: rtl/fmadd_round_arbiter.sv
// Round-robin share of the FMADD rounding unit between the add/sub and FMA paths.
// Two-stage pipe: S1 drives the rounding unit, S2 holds the rounded result.
module fmadd_round_arbiter #(
    parameter int man = 22,
    parameter int exp = 7,
    parameter int TAG = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [man+exp+13:0]  req0_data,
    input  logic [TAG-1:0]       req0_tag,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [man+exp+13:0]  req1_data,
    input  logic [TAG-1:0]       req1_tag,

    input  logic [2:0]           csr_frm,

    output logic [man+1:0]       rnd_mantissa,
    output logic [exp+1:0]       rnd_exponent,
    output logic                 rnd_sign,
    output logic                 rnd_guard,
    output logic                 rnd_round,
    output logic                 rnd_sticky,
    output logic [2:0]           rnd_frm,
    output logic                 rnd_a_eq_b,
    output logic                 rnd_uf_a,
    output logic                 rnd_nx_mul,

    input  logic [man:0]         rnd_res_mantissa,
    input  logic [exp:0]         rnd_res_exponent,
    input  logic                 rnd_res_sign,
    input  logic [2:0]           rnd_res_flags,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [exp+man+2:0]   out_result,
    output logic [2:0]           out_flags,
    output logic                 out_src,
    output logic [TAG-1:0]       out_tag,
    output logic                 out_illegal,

    input  logic                 fflags_clr,
    output logic [4:0]           fflags_acc
);

    localparam int DW   = man + exp + 14;
    localparam int M_LO = 9;
    localparam int M_HI = man + 10;
    localparam int E_LO = man + 11;
    localparam int E_HI = man + exp + 12;
    localparam int S_B  = man + exp + 13;

    logic           s1_valid;
    logic           s1_src;
    logic           s1_illegal;
    logic [TAG-1:0] s1_tag;
    logic           rr_ptr;

    logic           s2_load;
    logic           s1_can_load;
    logic           grant0;
    logic           grant1;
    logic           accept;

    logic [DW-1:0]  sel_data;
    logic [TAG-1:0] sel_tag;
    logic [2:0]     res_frm;
    logic           res_illegal;
    logic           out_fire;
    logic [4:0]     acc_next;

    assign s2_load     = s1_valid & (!out_valid | out_ready);
    assign s1_can_load = !s1_valid | s2_load;

    // On contention rr_ptr picks the winner; a lone requester always wins.
    assign grant0 = s1_can_load & req0_valid & (!req1_valid | !rr_ptr);
    assign grant1 = s1_can_load & req1_valid & (!req0_valid | rr_ptr);
    assign accept = grant0 | grant1;

    assign req0_ready = grant0 & !rst;
    assign req1_ready = grant1 & !rst;

    always_comb begin
        sel_data = req0_data;
        sel_tag  = req0_tag;
        if (grant1) begin
            sel_data = req1_data;
            sel_tag  = req1_tag;
        end
    end

    always_comb begin
        res_frm = sel_data[5:3];
        if (sel_data[5:3] == 3'b111) begin
            res_frm = csr_frm;
        end
        res_illegal = res_frm[2] & (res_frm[1] | res_frm[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= grant0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_src       <= 1'b0;
            s1_illegal   <= 1'b0;
            s1_tag       <= '0;
            rnd_mantissa <= '0;
            rnd_exponent <= '0;
            rnd_sign     <= 1'b0;
            rnd_guard    <= 1'b0;
            rnd_round    <= 1'b0;
            rnd_sticky   <= 1'b0;
            rnd_frm      <= 3'b000;
            rnd_a_eq_b   <= 1'b0;
            rnd_uf_a     <= 1'b0;
            rnd_nx_mul   <= 1'b0;
        end else if (s1_can_load) begin
            s1_valid <= accept;
            if (accept) begin
                s1_src       <= grant1;
                s1_illegal   <= res_illegal;
                s1_tag       <= sel_tag;
                rnd_sign     <= sel_data[S_B];
                rnd_exponent <= sel_data[E_HI:E_LO];
                rnd_mantissa <= sel_data[M_HI:M_LO];
                rnd_guard    <= sel_data[8];
                rnd_round    <= sel_data[7];
                rnd_sticky   <= sel_data[6];
                rnd_frm      <= res_illegal ? 3'b000 : res_frm;
                rnd_a_eq_b   <= sel_data[2];
                rnd_uf_a     <= sel_data[1];
                rnd_nx_mul   <= sel_data[0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_flags   <= 3'b000;
            out_src     <= 1'b0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (s2_load) begin
            out_valid   <= 1'b1;
            out_src     <= s1_src;
            out_tag     <= s1_tag;
            out_illegal <= s1_illegal;
            if (s1_illegal) begin
                out_result <= '0;
                out_flags  <= 3'b000;
            end else begin
                out_result <= {rnd_res_sign, rnd_res_exponent, rnd_res_mantissa};
                out_flags  <= rnd_res_flags;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_fire = out_valid & out_ready;

    // Clear first, then merge this cycle's result so its bits survive.
    always_comb begin
        acc_next = fflags_acc;
        if (fflags_clr) begin
            acc_next = 5'b00000;
        end
        if (out_fire) begin
            if (out_illegal) begin
                acc_next[4] = 1'b1;
            end else begin
                acc_next[2] = acc_next[2] | out_flags[1];
                acc_next[1] = acc_next[1] | out_flags[2];
                acc_next[0] = acc_next[0] | out_flags[0];
            end
        end
        acc_next[3] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fflags_acc <= 5'b00000;
        end else begin
            fflags_acc <= acc_next;
        end
    end

endmodule
